pps_pkt_rx_buffer: RTL
======================

// Module: pps_pkt_rx_buffer
// PURPOSE
//  Receiving end of the 134-bit pkt/valid/almostfull stage-to-stage bus used across the PPS pipeline.
//  Absorbs an upstream stage's packet stream into a data FIFO plus a per-packet verdict FIFO.
//  Drives almostfull back upstream and replays kept packets onto an identical downstream bus.
//  Drops packets whose verdict is 0.
//  Sits in front of any stage lacking its own input buffering (e.g. a TDMA/EGRESS feed).
// PARAMETERS
//  DATA_AW      8    log2 data FIFO depth (256 x 134b words)
//  VALID_AW     6    log2 verdict FIFO depth (64 x 1b)
//  DATA_AFULL   160  data FIFO used-words threshold for almostfull (leaves >=96 words = 1 max pkt)
//  VALID_AFULL  60   verdict FIFO used-entries threshold for almostfull
// PORTS
//  clk                 in   1    clock
//  reset               in   1    synchronous, active-high reset
//  in_pkt_wr           in   1    data word strobe
//  in_pkt              in   134  [133:132] 01 head, 11 middle, 10 tail; [131:128] invalid bytes in tail; [127:0] data
//  in_valid_wr         in   1    verdict strobe, one per packet, at or after tail word
//  in_valid            in   1    1 keep, 0 discard
//  out_pkt_almostfull  out  1    backpressure to upstream
//  out_pkt_wr          out  1    data word strobe downstream
//  out_pkt             out  134  data word downstream
//  out_valid_wr        out  1    verdict strobe downstream (with tail word)
//  out_valid           out  1    verdict downstream (always 1 when out_valid_wr)
//  in_pkt_almostfull   in   1    downstream backpressure
//  out_fwd_cnt         out  32   packets forwarded, wraps at 2^32
//  out_drop_cnt        out  32   packets discarded by verdict, wraps
//  out_ovf_cnt         out  16   words/verdicts lost to FIFO-full writes, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0 (out_pkt 134'b0), FIFOs emptied, FSM=IDLE, counters 0.
//   Reset mid-packet abandons any partial packet without emitting a tail.
//  Write side: in_pkt_wr pushes in_pkt; in_valid_wr pushes in_valid. Independent; same-cycle push allowed.
//   Push to a full FIFO: word discarded, out_ovf_cnt+1 (both FIFOs full same cycle = +1 only).
//  out_pkt_almostfull: registered; 1 the cycle after data used >= DATA_AFULL or verdict used >= VALID_AFULL.
//   Upstream obeys it at packet boundaries only.
//  Read side FSM, FIFOs show-ahead:
//   IDLE: if verdict FIFO non-empty AND data FIFO non-empty AND !in_pkt_almostfull:
//         pop verdict; ->SEND if 1, ->DROP if 0. Else stay.
//   SEND: pop one data word per cycle while data FIFO non-empty (stall, no strobe, when empty).
//         Registered output: out_pkt_wr=1, out_pkt=word, 1 cycle after pop.
//         On tail word ([133:132]==10): out_valid_wr=1, out_valid=1 same cycle as tail strobe;
//         out_fwd_cnt+1; ->IDLE.
//         in_pkt_almostfull ignored mid-packet.
//   DROP: pop words, no output; on tail pop out_drop_cnt+1, ->IDLE.
//  Packet start: IDLE->SEND decision cycle + 1 register stage; first out_pkt_wr 2 cycles after verdict available.
//   Back-to-back packets: 1 idle cycle between tail and next head on output.
//  Head/middle codes not checked; only tail terminates a packet. Verdict may arrive after its tail word is already buffered.
//  Simultaneous push and pop on either FIFO: used count unchanged; full/empty flags exact.
// STRUCTURE
//  Shared package pps_bus_pkg: PKT_W=134, HDR_HEAD=2'b01, HDR_MID=2'b11, HDR_TAIL=2'b10,
//   and the pkt field slice macros. Also reused by INGRESS/EGRESS/DISPATHER benches.
//  One sub-module: pps_sync_fifo (param width/addr width, show-ahead, used count, full/empty),
//   instantiated twice (data, verdict).
//  Top holds FSM, output register stage, counters, almostfull compare.
// TESTING
//  1 Single 4-word pkt (head,mid,mid,tail), verdict 1 -> 4 out_pkt_wr strobes matching input;
//    out_valid_wr/out_valid=1 on tail; out_fwd_cnt=1.
//  2 Same pkt, verdict 0 -> no out_pkt_wr; out_drop_cnt=1; FIFOs empty afterwards.
//  3 Push 160 words without draining (in_pkt_almostfull=1) -> out_pkt_almostfull rises the cycle after word 160.
//    Falls after downstream drains below 160.
//  4 in_pkt_almostfull rises mid-packet -> current pkt completes.
//    Next pkt does not start until in_pkt_almostfull=0.
//  5 Fill data FIFO to 256, push 3 more words -> out_ovf_cnt=3; stored 256 words intact.
//  6 reset asserted during word 2 of a SEND pkt -> next cycle all outputs 0, counters 0.
//    A fresh 2-word pkt then forwards correctly.

Source files
------------

// File: rtl/pps_bus_pkg.sv
// Shared definitions for the 134-bit pkt/valid/almostfull stage-to-stage bus.
// Field helpers stand in for slice macros so every stage decodes headers identically.
package pps_bus_pkg;

  localparam int PKT_W = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  function automatic logic [1:0] pkt_hdr(input logic [PKT_W-1:0] w);
    return w[PKT_W-1 -: 2];
  endfunction

  function automatic logic [3:0] pkt_invalid_bytes(input logic [PKT_W-1:0] w);
    return w[PKT_W-3 -: 4];
  endfunction

  function automatic logic [127:0] pkt_data(input logic [PKT_W-1:0] w);
    return w[127:0];
  endfunction

  function automatic logic pkt_is_tail(input logic [PKT_W-1:0] w);
    return pkt_hdr(w) == HDR_TAIL;
  endfunction

endpackage

// File: rtl/pps_sync_fifo.sv
// Show-ahead synchronous FIFO on an inferred RAM with a registered read port.
// The read address is looked ahead one cycle, with a write bypass, so o_dout always shows the head entry.
module pps_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_used
);

  localparam logic [AW:0] LP_DEPTH = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [0:(2**AW)-1];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_used;
  logic [WIDTH-1:0] r_dout;

  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_next;

  assign w_full    = (r_used == LP_DEPTH);
  assign w_empty   = (r_used == '0);
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_rd_next = r_rd_ptr + AW'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_next;
      // A word written into the slot about to become the head bypasses the RAM read.
      if (w_push_ok && (r_wr_ptr == w_rd_next)) begin
        r_dout <= i_din;
      end else begin
        r_dout <= r_mem[w_rd_next];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  assign o_dout  = r_dout;
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_used  = r_used;

endmodule

// File: rtl/pps_pkt_rx_buffer.sv
// Receive buffer for the PPS stage bus: data + verdict FIFOs, replay FSM that forwards kept
// packets and silently drops rejected ones, plus backpressure and statistics counters.
module pps_pkt_rx_buffer
  import pps_bus_pkg::*;
#(
  parameter int DATA_AW     = 8,
  parameter int VALID_AW    = 6,
  parameter int DATA_AFULL  = 160,
  parameter int VALID_AFULL = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_pkt_wr,
  input  logic [PKT_W-1:0] in_pkt,
  input  logic             in_valid_wr,
  input  logic             in_valid,
  output logic             out_pkt_almostfull,
  output logic             out_pkt_wr,
  output logic [PKT_W-1:0] out_pkt,
  output logic             out_valid_wr,
  output logic             out_valid,
  input  logic             in_pkt_almostfull,
  output logic [31:0]      out_fwd_cnt,
  output logic [31:0]      out_drop_cnt,
  output logic [15:0]      out_ovf_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]       r_state;
  logic             r_out_pkt_wr;
  logic [PKT_W-1:0] r_out_pkt;
  logic             r_out_valid_wr;
  logic             r_out_valid;
  logic             r_afull;
  logic [31:0]      r_fwd_cnt;
  logic [31:0]      r_drop_cnt;
  logic [15:0]      r_ovf_cnt;

  logic [PKT_W-1:0] w_d_dout;
  logic             w_d_empty;
  logic             w_d_full;
  logic [DATA_AW:0] w_d_used;
  logic [0:0]       w_v_dout;
  logic             w_v_empty;
  logic             w_v_full;
  logic [VALID_AW:0] w_v_used;
  logic             w_d_pop;
  logic             w_v_pop;
  logic             w_d_tail;
  logic             w_ovf;
  logic             w_afull_next;

  pps_sync_fifo #(.WIDTH(PKT_W), .AW(DATA_AW)) u_data_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_pkt_wr),
    .i_din   (in_pkt),
    .i_pop   (w_d_pop),
    .o_dout  (w_d_dout),
    .o_empty (w_d_empty),
    .o_full  (w_d_full),
    .o_used  (w_d_used)
  );

  pps_sync_fifo #(.WIDTH(1), .AW(VALID_AW)) u_valid_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid_wr),
    .i_din   (in_valid),
    .i_pop   (w_v_pop),
    .o_dout  (w_v_dout),
    .o_empty (w_v_empty),
    .o_full  (w_v_full),
    .o_used  (w_v_used)
  );

  assign w_d_tail     = pkt_is_tail(w_d_dout);
  // Both FIFOs rejecting in the same cycle counts as a single loss event.
  assign w_ovf        = (in_pkt_wr && w_d_full) || (in_valid_wr && w_v_full);
  assign w_afull_next = (w_d_used >= (DATA_AW+1)'(DATA_AFULL)) ||
                        (w_v_used >= (VALID_AW+1)'(VALID_AFULL));

  always_comb begin
    w_v_pop = 1'b0;
    w_d_pop = 1'b0;
    case (r_state)
      IDLE:       w_v_pop = !w_v_empty && !w_d_empty && !in_pkt_almostfull;
      SEND, DROP: w_d_pop = !w_d_empty;
      default:    w_d_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_out_pkt_wr   <= 1'b0;
      r_out_pkt      <= '0;
      r_out_valid_wr <= 1'b0;
      r_out_valid    <= 1'b0;
      r_afull        <= 1'b0;
      r_fwd_cnt      <= '0;
      r_drop_cnt     <= '0;
      r_ovf_cnt      <= '0;
    end else begin
      r_out_pkt_wr   <= 1'b0;
      r_out_valid_wr <= 1'b0;
      r_out_valid    <= 1'b0;
      r_afull        <= w_afull_next;
      if (w_ovf && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_v_pop) begin
            r_state <= w_v_dout[0] ? SEND : DROP;
          end
        end
        SEND: begin
          if (w_d_pop) begin
            r_out_pkt_wr <= 1'b1;
            r_out_pkt    <= w_d_dout;
            if (w_d_tail) begin
              r_out_valid_wr <= 1'b1;
              r_out_valid    <= 1'b1;
              r_fwd_cnt      <= r_fwd_cnt + 32'd1;
              r_state        <= IDLE;
            end
          end
        end
        DROP: begin
          if (w_d_pop && w_d_tail) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_pkt_almostfull = r_afull;
  assign out_pkt_wr         = r_out_pkt_wr;
  assign out_pkt            = r_out_pkt;
  assign out_valid_wr       = r_out_valid_wr;
  assign out_valid          = r_out_valid;
  assign out_fwd_cnt        = r_fwd_cnt;
  assign out_drop_cnt       = r_drop_cnt;
  assign out_ovf_cnt        = r_ovf_cnt;

endmodule
